// File: rtl/lib_cmps_from_pow2.sv
// Rebuilds a vector from a serial stream of one-hot terms.
// Each frame ends on s_last; the result carries a term count and error flags.
module lib_cmps_from_pow2 #(
  parameter int WIDTH     = 4,
  parameter int TERMS_MAX = WIDTH,
  parameter int CNT_W     = $clog2(TERMS_MAX + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_onehot,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_vect,
  output logic [CNT_W-1:0] m_cnt,
  output logic [2:0]       m_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TERMS_MAX);

  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       err;

  logic [WIDTH-1:0] nxt_acc;
  logic [CNT_W-1:0] nxt_cnt;
  logic [2:0]       nxt_err;
  logic             take;
  logic             t_nz;
  logic             multi;

  assign s_ready = ~m_valid | m_ready;
  assign take    = s_valid & s_ready;
  assign t_nz    = |s_onehot;
  // clearing the lowest set bit leaves something only if 2+ bits set
  assign multi   = |(s_onehot & (s_onehot - WIDTH'(1)));

  always_comb begin
    nxt_acc    = acc | s_onehot;
    nxt_cnt    = cnt;
    nxt_err    = err;
    nxt_err[0] = err[0] | multi;
    nxt_err[1] = err[1] | (|(acc & s_onehot));
    if (t_nz) begin
      if (cnt == CNT_MAX) begin
        nxt_err[2] = 1'b1;
      end else begin
        nxt_cnt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc     <= '0;
      cnt     <= '0;
      err     <= '0;
      m_valid <= 1'b0;
      m_vect  <= '0;
      m_cnt   <= '0;
      m_err   <= '0;
    end else begin
      if (take && s_last) begin
        acc     <= '0;
        cnt     <= '0;
        err     <= '0;
        m_valid <= 1'b1;
        m_vect  <= nxt_acc;
        m_cnt   <= nxt_cnt;
        m_err   <= nxt_err;
      end else begin
        if (take) begin
          acc <= nxt_acc;
          cnt <= nxt_cnt;
          err <= nxt_err;
        end
        if (m_valid && m_ready) begin
          m_valid <= 1'b0;
        end
      end
    end
  end

endmodule
